wb_sram_slave: RTL and testbench
================================

WB_SRAM_SLAVE -- requirements
Module: wb_sram_slave

Interface
REQ-001 SHALL have parameter MEM_BYTES, 65536, memory size in bytes, a power of two and at least 4.
REQ-002 SHALL have parameter WAIT_STATES, 1, extra cycles between request accept and first beat, range 0..15.
REQ-003 SHALL have parameter BL_WIDTH, 10, burst-length field width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports, as name, direction, width, meaning:
- clk_i  in  1  clock, rising edge.
- rst_n  in  1  async active-low reset.
- s_wbd_cyc_i  in  1  bus cycle active.
- s_wbd_stb_i  in  1  request strobe.
- s_wbd_we_i  in  1  1 = write, 0 = read.
- s_wbd_adr_i  in  32  byte address, word-aligned; bits [1:0] ignored.
- s_wbd_sel_i  in  4  byte-lane enables, bit n = byte n.
- s_wbd_dat_i  in  32  write data.
- s_wbd_bl_i  in  BL_WIDTH  burst length in beats; 0 is treated as 1.
- s_wbd_bry_i  in  1  master ready for the current beat.
- s_wbd_dat_o  out  32  read data, valid while ack is high.
- s_wbd_ack_o  out  1  beat acknowledge.
- s_wbd_lack_o  out  1  last-beat acknowledge.
- s_wbd_err_o  out  1  error termination.

Function
REQ-006 SHALL hold internal storage of MEM_BYTES/4 32-bit words; storage SHALL NOT be cleared by reset.
REQ-007 SHALL implement FSM states IDLE, WAIT, BEAT, ERR.
REQ-008 IDLE: when cyc&stb is sampled, SHALL latch adr[31:2], we and beats = max(bl,1), and load the wait counter with WAIT_STATES.
- If the address is at or beyond MEM_BYTES, the next state SHALL be ERR.
- Otherwise, if WAIT_STATES = 0, the next state SHALL be BEAT.
- Otherwise, the next state SHALL be WAIT.
REQ-009 WAIT: SHALL decrement the counter each cycle and go to BEAT when the counter reaches 0, so the first beat is available WAIT_STATES+1 cycles after accept.
REQ-010 BEAT: s_wbd_ack_o SHALL equal (state==BEAT && s_wbd_bry_i && s_wbd_cyc_i), and it SHALL be combinational from registered state.
REQ-011 For reads, s_wbd_dat_o SHALL present mem[beat_addr], registered on entry to BEAT and reloaded after each acked beat with the next word.
REQ-012 For writes, on each acked beat, each byte lane n with sel[n]=1 SHALL be written from dat_i[8n+7:8n] at beat_addr at the clock edge; lanes with sel[n]=0 SHALL stay unchanged.
REQ-013 After each acked beat, beat_addr SHALL increment by one word and the remaining-beat count SHALL decrement.
REQ-014 s_wbd_lack_o SHALL be asserted together with ack on the final beat only; the next state SHALL then be IDLE.
REQ-015 If bry_i is low in BEAT, the block SHALL stall: no ack, no address/count change, and read data held.
REQ-016 If beat_addr increments to MEM_BYTES or beyond mid-burst, the block SHALL go to ERR instead of issuing the next beat.
REQ-017 ERR: s_wbd_err_o SHALL be high for exactly one cycle with no ack and no write; the next state SHALL be IDLE.
REQ-018 If cyc_i is deasserted in WAIT or BEAT, the block SHALL return to IDLE the next cycle with no further ack, lack or write.
REQ-019 ack, lack and err SHALL be mutually exclusive and SHALL be 0 whenever cyc_i=0.
REQ-020 A new request SHALL be accepted at the earliest in the cycle after returning to IDLE; back-to-back transfers SHALL be supported.
REQ-021 bl_i, we_i and adr_i SHALL be sampled only at accept; changes to them mid-burst SHALL be ignored, while sel_i and dat_i SHALL be used per beat.

Reset
REQ-022 While rst_n=0, the block SHALL hold state=IDLE, ack=0, lack=0, err=0, dat_o=0 and all counters/address registers at 0, asynchronously.
REQ-023 Reset asserted mid-burst SHALL abort the burst immediately; writes not yet acked SHALL NOT occur.
REQ-024 The first request after the rst_n rise SHALL be accepted no earlier than the first clock edge with rst_n=1.

Verification
REQ-025 With WAIT_STATES=1, write 0xDEADBEEF to 0x10 with sel=0xF, bl=1, then read 0x10 -> ack and lack together exactly 2 cycles after each accept, and read data 0xDEADBEEF.
REQ-026 With word 0x14 = 0x11223344, write 0x0000AB00 with sel=4'b0010 -> reading 0x14 returns 0x1122AB44.
REQ-027 Preload 0x20..0x2C with 1,2,3,4, then burst read bl=4 with bry_i pattern 1,0,1,1,0,1 -> 4 acks carrying data 1,2,3,4, lack only with 4, and no ack on bry_i=0 cycles.
REQ-028 Read at 0x00010000 (MEM_BYTES=65536) -> err_o for one cycle, no ack; a burst write bl=3 starting at 0xFFF8 -> 2 acks, then err_o, and nothing written beyond 0xFFFC.
REQ-029 Drop cyc_i after 2 beats of a bl=4 write, then pulse rst_n low during a later burst -> only the 2 acked words are written, and all outputs read 0 while reset is low.

Source files
------------

// File: rtl/wb_sram_if.sv
// Wishbone-style burst bus between a master and the SRAM slave.
// Master drives cycle/strobe/request fields, the per-beat ready and write data.
// The slave returns read data and the ack / last-ack / error terminations.
interface wb_sram_if #(
  parameter int BL_WIDTH = 10
);
  logic                s_wbd_cyc_i;
  logic                s_wbd_stb_i;
  logic                s_wbd_we_i;
  logic [31:0]         s_wbd_adr_i;
  logic [3:0]          s_wbd_sel_i;
  logic [31:0]         s_wbd_dat_i;
  logic [BL_WIDTH-1:0] s_wbd_bl_i;
  logic                s_wbd_bry_i;
  logic [31:0]         s_wbd_dat_o;
  logic                s_wbd_ack_o;
  logic                s_wbd_lack_o;
  logic                s_wbd_err_o;

  modport master (
    output s_wbd_cyc_i, s_wbd_stb_i, s_wbd_we_i, s_wbd_adr_i, s_wbd_sel_i,
           s_wbd_dat_i, s_wbd_bl_i, s_wbd_bry_i,
    input  s_wbd_dat_o, s_wbd_ack_o, s_wbd_lack_o, s_wbd_err_o
  );

  modport slave (
    input  s_wbd_cyc_i, s_wbd_stb_i, s_wbd_we_i, s_wbd_adr_i, s_wbd_sel_i,
           s_wbd_dat_i, s_wbd_bl_i, s_wbd_bry_i,
    output s_wbd_dat_o, s_wbd_ack_o, s_wbd_lack_o, s_wbd_err_o
  );
endinterface

// File: rtl/wb_sram_slave.sv
// Burst SRAM slave on the wb_sram_if bus.
// Ports:
//   clk_i  - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   s_wbd  - slave modport: request (cyc/stb/we/adr/bl), per-beat sel/dat/bry,
//            response dat_o/ack/lack/err
// A request is latched in IDLE, optionally delayed WAIT_STATES cycles, then
// beats are transferred whenever the master is ready. Addresses outside the
// memory, at request time or when a burst runs off the end, terminate with a
// single-cycle error.
module wb_sram_slave #(
  parameter int MEM_BYTES   = 65536,
  parameter int WAIT_STATES = 1,
  parameter int BL_WIDTH    = 10
) (
  input logic      clk_i,
  input logic      rst_n,
  wb_sram_if.slave s_wbd
);
  localparam int WORDS = MEM_BYTES / 4;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_ERR} state_t;

  // Latched burst context: direction, current word address, beats remaining.
  typedef struct packed {
    logic                we;
    logic [29:0]         addr;
    logic [BL_WIDTH-1:0] left;
  } burst_t;

  state_t              st, nxt;
  burst_t              cur;
  logic [3:0]          wait_cnt;
  logic [31:0]         dat_q;
  logic [31:0]         mem [WORDS];

  logic                cyc, req, adr_bad, nxt_bad;
  logic                ack, lack, err;
  logic [29:0]         nxt_addr;
  logic [BL_WIDTH-1:0] beats_in;
  logic                rd_we, rd_load;
  logic [AW-1:0]       rd_idx;
  logic                unused_adr;

  assign cyc        = s_wbd.s_wbd_cyc_i;
  assign req        = cyc & s_wbd.s_wbd_stb_i;
  assign adr_bad    = {2'b00, s_wbd.s_wbd_adr_i[31:2]} >= 32'(WORDS);
  assign nxt_addr   = cur.addr + 30'd1;
  assign nxt_bad    = {2'b00, nxt_addr} >= 32'(WORDS);
  assign beats_in   = (s_wbd.s_wbd_bl_i == '0) ? BL_WIDTH'(1) : s_wbd.s_wbd_bl_i;
  assign unused_adr = ^s_wbd.s_wbd_adr_i[1:0];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= nxt;
  end

  // Terminations depend only on registered state plus cyc/bry, so every
  // response is forced low the moment cyc drops.
  always_comb begin
    nxt  = st;
    ack  = 1'b0;
    lack = 1'b0;
    err  = 1'b0;
    case (st)
      S_IDLE: begin
        if (req) begin
          if (adr_bad)               nxt = S_ERR;
          else if (WAIT_STATES == 0) nxt = S_BEAT;
          else                       nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!cyc)               nxt = S_IDLE;
        else if (wait_cnt <= 1) nxt = S_BEAT;
      end
      S_BEAT: begin
        if (!cyc) nxt = S_IDLE;
        else if (s_wbd.s_wbd_bry_i) begin
          ack = 1'b1;
          if (cur.left == BL_WIDTH'(1)) begin
            lack = 1'b1;
            nxt  = S_IDLE;
          end else if (nxt_bad) begin
            nxt = S_ERR;
          end
        end
      end
      S_ERR: begin
        err = cyc;
        nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Read data is fetched one edge ahead: on entry to BEAT (from the request
  // address when there is no wait phase) and after each acked beat that
  // stays in BEAT. A stall leaves dat_q untouched.
  always_comb begin
    rd_we = cur.we;
    rd_idx = nxt_addr[AW-1:0];
    if (st == S_IDLE) begin
      rd_we  = s_wbd.s_wbd_we_i;
      rd_idx = s_wbd.s_wbd_adr_i[AW+1:2];
    end else if (st == S_WAIT) begin
      rd_idx = cur.addr[AW-1:0];
    end
  end

  assign rd_load = (nxt == S_BEAT) && !rd_we && ((st != S_BEAT) || ack);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= '0;
      wait_cnt <= '0;
      dat_q    <= '0;
    end else begin
      if (st == S_IDLE) begin
        if (req) begin
          cur.we   <= s_wbd.s_wbd_we_i;
          cur.addr <= s_wbd.s_wbd_adr_i[31:2];
          cur.left <= beats_in;
          wait_cnt <= 4'(WAIT_STATES);
        end
      end else if (st == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end else if (ack) begin
        cur.addr <= nxt_addr;
        cur.left <= cur.left - BL_WIDTH'(1);
      end
      if (rd_load) dat_q <= mem[rd_idx];
    end
  end

  // Storage has no reset; ack is already low under reset so no write slips in.
  always_ff @(posedge clk_i) begin
    if (ack && cur.we) begin
      for (int n = 0; n < 4; n++) begin
        if (s_wbd.s_wbd_sel_i[n]) mem[cur.addr[AW-1:0]][8*n +: 8] <= s_wbd.s_wbd_dat_i[8*n +: 8];
      end
    end
  end

  assign s_wbd.s_wbd_dat_o  = dat_q;
  assign s_wbd.s_wbd_ack_o  = ack;
  assign s_wbd.s_wbd_lack_o = lack;
  assign s_wbd.s_wbd_err_o  = err;
endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench for wb_sram_slave: directed scenarios plus randomized
// bursts, checked cycle by cycle against a transaction-level memory model.
module tb_wb_sram_slave;
  localparam int MEM_BYTES = 65536;
  localparam int WS        = 1;
  localparam int BL_W      = 10;
  localparam int WORDS     = MEM_BYTES / 4;

  logic clk_i, rst_n;
  wb_sram_if #(.BL_WIDTH(BL_W)) bus ();

  wb_sram_slave #(.MEM_BYTES(MEM_BYTES), .WAIT_STATES(WS), .BL_WIDTH(BL_W)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .s_wbd (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [int];   // known memory contents, by word index
  logic [31:0] wq[$];           // per-beat write data (random if empty)
  logic [3:0]  sq[$];           // per-beat byte enables (random if empty)
  bit          bq[$];           // per-cycle ready pattern (random if empty)
  logic [31:0] rd_q[$];         // read data captured on acked beats

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_at(input int i);
    if (i < rd_q.size()) return rd_q[i];
    return 'x;
  endfunction

  task automatic mdl_wr(input int w, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    if (ref_mem.exists(w)) begin
      v = ref_mem[w];
      for (int n = 0; n < 4; n++) if (s[n]) v[8*n +: 8] = d[8*n +: 8];
      ref_mem[w] = v;
    end else if (s == 4'hF) begin
      ref_mem[w] = d;
    end
  endtask

  task automatic clrq();
    wq.delete(); sq.delete(); bq.delete();
  endtask

  // Fields sampled only at accept get garbage afterwards.
  task automatic scramble();
    bus.s_wbd_stb_i = 1'($urandom_range(0, 1));
    bus.s_wbd_we_i  = 1'($urandom_range(0, 1));
    bus.s_wbd_adr_i = $urandom;
    bus.s_wbd_bl_i  = BL_W'($urandom);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"},  32'(bus.s_wbd_ack_o),  32'd0);
    chk({tag, "_lack"}, 32'(bus.s_wbd_lack_o), 32'd0);
    chk({tag, "_err"},  32'(bus.s_wbd_err_o),  32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      bus.s_wbd_cyc_i = 1'b0;
      bus.s_wbd_stb_i = 1'($urandom_range(0, 1));
      bus.s_wbd_bry_i = 1'($urandom_range(0, 1));
      #1 chk_quiet("idle");
    end
  endtask

  // One transaction from the accept cycle to its termination. Expected
  // timing: first beat opportunity WS+1 cycles after accept, an ack on every
  // ready cycle, lack on the last beat, error in place of any beat whose
  // word lies outside memory. drop >= 0 removes cyc before that beat.
  task automatic xfer(input bit we, input logic [31:0] adr, input int bl, input int drop);
    int beats, k, w;
    bit b;
    logic [31:0] d;
    logic [3:0] s;
    beats = (bl == 0) ? 1 : bl;
    w     = int'(adr >> 2);
    @(negedge clk_i);
    bus.s_wbd_cyc_i = 1'b1;
    bus.s_wbd_stb_i = 1'b1;
    bus.s_wbd_we_i  = we;
    bus.s_wbd_adr_i = adr;
    bus.s_wbd_bl_i  = BL_W'(bl);
    bus.s_wbd_bry_i = 1'($urandom_range(0, 1));
    bus.s_wbd_sel_i = 4'($urandom);
    bus.s_wbd_dat_i = $urandom;
    #1 chk_quiet("accept");
    if (w >= WORDS) begin
      @(negedge clk_i); scramble();
      #1;
      chk("adr_err",  32'(bus.s_wbd_err_o),  32'd1);
      chk("adr_ack",  32'(bus.s_wbd_ack_o),  32'd0);
      chk("adr_lack", 32'(bus.s_wbd_lack_o), 32'd0);
      return;
    end
    repeat (WS) begin
      @(negedge clk_i); scramble();
      bus.s_wbd_bry_i = 1'($urandom_range(0, 1));
      #1 chk_quiet("wait");
    end
    k = 0;
    for (int t = 0; t < 64 && k < beats; t++) begin
      @(negedge clk_i); scramble();
      if (k == drop) begin
        bus.s_wbd_cyc_i = 1'b0;
        bus.s_wbd_stb_i = 1'b0;
        bus.s_wbd_bry_i = 1'b1;
        #1 chk_quiet("drop");
        return;
      end
      if (w >= WORDS) begin
        bus.s_wbd_bry_i = 1'($urandom_range(0, 1));
        #1;
        chk("run_err",  32'(bus.s_wbd_err_o),  32'd1);
        chk("run_ack",  32'(bus.s_wbd_ack_o),  32'd0);
        chk("run_lack", 32'(bus.s_wbd_lack_o), 32'd0);
        return;
      end
      b = (bq.size() != 0) ? bq.pop_front() : ($urandom_range(0, 3) != 0);
      d = (wq.size() != 0) ? wq[0] : $urandom;
      s = (sq.size() != 0) ? sq[0] : 4'($urandom);
      bus.s_wbd_bry_i = b;
      bus.s_wbd_dat_i = d;
      bus.s_wbd_sel_i = s;
      #1;
      chk("beat_ack",  32'(bus.s_wbd_ack_o),  32'(b));
      chk("beat_lack", 32'(bus.s_wbd_lack_o), 32'(b && (k == beats - 1)));
      chk("beat_err",  32'(bus.s_wbd_err_o),  32'd0);
      if (b) begin
        if (we) begin
          mdl_wr(w, d, s);
          if (wq.size() != 0) void'(wq.pop_front());
          if (sq.size() != 0) void'(sq.pop_front());
        end else begin
          rd_q.push_back(bus.s_wbd_dat_o);
          if (ref_mem.exists(w)) chk("rd_data", bus.s_wbd_dat_o, ref_mem[w]);
        end
        k++;
        w++;
      end
    end
    if (k < beats) chk("beat_budget", 32'(k), 32'(beats));
  endtask

  task automatic wr_burst(input logic [31:0] adr, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wq.push_back(base + 32'(i)); sq.push_back(4'hF); bq.push_back(1'b1);
    end
    xfer(1'b1, adr, n, -1);
    clrq();
  endtask

  task automatic wr1(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] s);
    wq.push_back(d); sq.push_back(s); bq.push_back(1'b1);
    xfer(1'b1, adr, 1, -1);
    clrq();
  endtask

  task automatic rd(input logic [31:0] adr, input int n);
    rd_q.delete();
    xfer(1'b0, adr, n, -1);
    clrq();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w, bl, drop, r;
    bit we;
    rst_n = 1'b0;
    bus.s_wbd_cyc_i = 1'b1;
    bus.s_wbd_stb_i = 1'b1;
    bus.s_wbd_we_i  = 1'b0;
    bus.s_wbd_adr_i = '0;
    bus.s_wbd_sel_i = '0;
    bus.s_wbd_dat_i = '0;
    bus.s_wbd_bl_i  = '0;
    bus.s_wbd_bry_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    chk_quiet("reset");
    chk("reset_dat", bus.s_wbd_dat_o, 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    bus.s_wbd_cyc_i = 1'b0;
    bus.s_wbd_stb_i = 1'b0;

    // Single write then read, ready held high.
    wr1(32'h10, 32'hDEADBEEF, 4'hF);
    bq.push_back(1'b1);
    rd(32'h10, 1);
    chk("rd_10", rd_at(0), 32'hDEADBEEF);

    // Byte-lane merge.
    wr1(32'h14, 32'h11223344, 4'hF);
    wr1(32'h14, 32'h0000AB00, 4'b0010);
    bq.push_back(1'b1);
    rd(32'h14, 1);
    chk("rd_14_lane", rd_at(0), 32'h1122AB44);

    // Burst read with stalls.
    wr_burst(32'h20, 32'd1, 4);
    bq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rd(32'h20, 4);
    chk("burst_cnt", 32'(rd_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("burst_dat", rd_at(i), 32'(i + 1));

    // Out-of-range request, then a write burst running off the end.
    rd(32'h0001_0000, 1);
    chk("oor_acks", 32'(rd_q.size()), 32'd0);
    wr1(32'h0, 32'hA5A5_0000, 4'hF);
    wr_burst(32'hFFF8, 32'h1111_0000, 2);
    wr_burst(32'hFFF8, 32'hC0DE_0001, 3);
    bq = '{1'b1, 1'b1};
    rd(32'hFFF8, 2);
    chk("end_w0", rd_at(0), 32'hC0DE_0001);
    chk("end_w1", rd_at(1), 32'hC0DE_0002);
    bq.push_back(1'b1);
    rd(32'h0, 1);
    chk("no_wrap", rd_at(0), 32'hA5A5_0000);

    // cyc dropped after two beats of a four-beat write.
    wr_burst(32'h40, 32'h4000_0000, 4);
    for (int i = 0; i < 4; i++) begin
      wq.push_back(32'h5000_0000 + 32'(i)); sq.push_back(4'hF); bq.push_back(1'b1);
    end
    xfer(1'b1, 32'h40, 4, 2);
    clrq();
    idle(1);
    bq = '{1'b1, 1'b1, 1'b1, 1'b1};
    rd(32'h40, 4);
    chk("drop_w0", rd_at(0), 32'h5000_0000);
    chk("drop_w1", rd_at(1), 32'h5000_0001);
    chk("drop_w2", rd_at(2), 32'h4000_0002);
    chk("drop_w3", rd_at(3), 32'h4000_0003);

    // Reset pulse after one acked beat of a write burst.
    wr_burst(32'h100, 32'h6000_0000, 4);
    @(negedge clk_i);
    bus.s_wbd_cyc_i = 1'b1; bus.s_wbd_stb_i = 1'b1; bus.s_wbd_we_i = 1'b1;
    bus.s_wbd_adr_i = 32'h100; bus.s_wbd_bl_i = BL_W'(4); bus.s_wbd_sel_i = 4'hF;
    bus.s_wbd_dat_i = 32'h7000_0000; bus.s_wbd_bry_i = 1'b1;
    #1 chk("rb_acc_ack", 32'(bus.s_wbd_ack_o), 32'd0);
    repeat (WS) begin
      @(negedge clk_i); bus.s_wbd_stb_i = 1'b0;
      #1 chk("rb_wait_ack", 32'(bus.s_wbd_ack_o), 32'd0);
    end
    @(negedge clk_i);
    #1 chk("rb_beat_ack", 32'(bus.s_wbd_ack_o), 32'd1);
    ref_mem[64] = 32'h7000_0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      bus.s_wbd_dat_i = 32'h7100_0000;
      rst_n = 1'b0;
      #1;
      chk_quiet("rb_rst");
      chk("rb_rst_dat", bus.s_wbd_dat_o, 32'd0);
    end
    @(negedge clk_i);
    rst_n = 1'b1;
    bus.s_wbd_cyc_i = 1'b0;
    bus.s_wbd_stb_i = 1'b0;
    bq = '{1'b1, 1'b1, 1'b1, 1'b1};
    rd(32'h100, 4);
    chk("rb_w0", rd_at(0), 32'h7000_0000);
    chk("rb_w1", rd_at(1), 32'h6000_0001);
    chk("rb_w2", rd_at(2), 32'h6000_0002);
    chk("rb_w3", rd_at(3), 32'h6000_0003);

    // Randomized traffic, mostly in a small window so reads hit known data.
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      w = WORDS + $urandom_range(0, 100);
      else if (r < 3)  w = WORDS - $urandom_range(1, 4);
      else             w = $urandom_range(0, 63);
      we   = 1'($urandom_range(0, 1));
      bl   = $urandom_range(0, 6);
      drop = ($urandom_range(0, 7) == 0) ? $urandom_range(0, (bl == 0) ? 0 : bl - 1) : -1;
      rd_q.delete();
      xfer(we, (32'(w) << 2) | 32'($urandom_range(0, 3)), bl, drop);
      idle($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
